mmio_bus: RTL

MMIO_BUS -- requirements
Module: mmio_bus

---
 rtl/mmio_pkg.sv | 50 +++++
 rtl/mmio_timer.sv | 59 +++++
 rtl/mmio_bus.sv | 114 +++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types, address map constants, region decode and the
// byte-strobe merge helper used by the memory-mapped bus and its timer.
package mmio_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam addr_t LEDR_ADDR        = 32'h1000_0000;
    localparam addr_t SW_ADDR          = 32'h1000_0004;
    localparam addr_t MTIME_LO_ADDR    = 32'h1000_0008;
    localparam addr_t MTIME_HI_ADDR    = 32'h1000_000C;
    localparam addr_t MTIMECMP_LO_ADDR = 32'h1000_0010;
    localparam addr_t MTIMECMP_HI_ADDR = 32'h1000_0014;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_LEDR,
        REG_SW,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_CMP_LO,
        REG_CMP_HI
    } region_e;

    // Misaligned or unmapped addresses decode to REG_NONE (error response).
    function automatic region_e decode(addr_t addr, int unsigned mem_words);
        if (addr[1:0] != 2'b00)                   return REG_NONE;
        if (addr < addr_t'(mem_words * 4))        return REG_RAM;
        case (addr)
            LEDR_ADDR:        return REG_LEDR;
            SW_ADDR:          return REG_SW;
            MTIME_LO_ADDR:    return REG_MTIME_LO;
            MTIME_HI_ADDR:    return REG_MTIME_HI;
            MTIMECMP_LO_ADDR: return REG_CMP_LO;
            MTIMECMP_HI_ADDR: return REG_CMP_HI;
            default:          return REG_NONE;
        endcase
    endfunction

    // Replace only the byte lanes selected by strb.
    function automatic data_t apply_strb(data_t old_v, data_t new_v, logic [3:0] strb);
        data_t r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: 64-bit mtime with prescaler, byte-writable mtimecmp,
// high-word shadow for atomic 64-bit reads, and registered timer_irq.
// Ports: clk, reset_n; cmp_wr/cmp_hi/wstrb/wdata write mtimecmp;
// shadow_latch captures mtime[63:32]; mtime_lo, mtimecmp, shadow and
// timer_irq are the register outputs.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmp_wr,
    input  logic        cmp_hi,
    input  logic [3:0]  wstrb,
    input  data_t       wdata,
    input  logic        shadow_latch,
    output data_t       mtime_lo,
    output logic [63:0] mtimecmp,
    output data_t       shadow,
    output logic        timer_irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [63:0]   mtime;
    logic          tick;

    assign tick     = (presc == PW'(TICK_DIV - 1));
    assign mtime_lo = mtime[31:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            shadow    <= '0;
            timer_irq <= 1'b0;
        end else begin
            if (tick) begin
                presc <= '0;
                mtime <= mtime + 64'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            if (cmp_wr) begin
                if (cmp_hi) mtimecmp[63:32] <= apply_strb(mtimecmp[63:32], wdata, wstrb);
                else        mtimecmp[31:0]  <= apply_strb(mtimecmp[31:0],  wdata, wstrb);
            end
            // Same-edge capture as the LO read data, so LO/HI form one snapshot.
            if (shadow_latch) shadow <= mtime[63:32];
            timer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/mmio_bus.sv
// mmio_bus: single-cycle, fully pipelined memory-mapped bus with RAM, LED
// register, synchronised switches and a machine timer.
// Ports: clk, reset_n; request req_valid/req_ready/req_addr/req_wdata/
// req_wstrb (wstrb==0 is a read); response rsp_valid/rsp_rdata/rsp_err one
// cycle later; ledr LED register; sw_in async switches; timer_irq.
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LED_WIDTH = 10,
    parameter int SW_WIDTH  = 10,
    parameter int TICK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  addr_t                req_addr,
    input  data_t                req_wdata,
    input  logic [3:0]           req_wstrb,
    output logic                 rsp_valid,
    output data_t                rsp_rdata,
    output logic                 rsp_err,
    output logic [LED_WIDTH-1:0] ledr,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic                 timer_irq
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    data_t               mem [MEM_WORDS];
    region_e             region;
    logic                is_wr;
    logic [IDX_W-1:0]    ram_idx;
    logic [SW_WIDTH-1:0] sw_meta, sw_sync;
    data_t               rd_data;
    logic                dec_err;
    data_t               mtime_lo, shadow;
    logic [63:0]         mtimecmp;

    assign req_ready = 1'b1;
    assign region    = decode(req_addr, MEM_WORDS);
    assign is_wr     = |req_wstrb;
    assign ram_idx   = req_addr[IDX_W+1:2];

    // NOTE: RAM has no reset so it maps onto block memory; its contents
    // survive reset_n by design.
    always_ff @(posedge clk) begin
        if (req_valid && is_wr && region == REG_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wstrb[i]) mem[ram_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ledr    <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (req_valid && is_wr && region == REG_LEDR)
                ledr <= LED_WIDTH'(apply_strb(data_t'(ledr), req_wdata, req_wstrb));
        end
    end

    mmio_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmp_wr       (req_valid && is_wr && (region == REG_CMP_LO || region == REG_CMP_HI)),
        .cmp_hi       (region == REG_CMP_HI),
        .wstrb        (req_wstrb),
        .wdata        (req_wdata),
        .shadow_latch (req_valid && !is_wr && region == REG_MTIME_LO),
        .mtime_lo     (mtime_lo),
        .mtimecmp     (mtimecmp),
        .shadow       (shadow),
        .timer_irq    (timer_irq)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rd_data = '0;
        dec_err = 1'b0;
        case (region)
            REG_RAM:      rd_data = mem[ram_idx];
            REG_LEDR:     rd_data = data_t'(ledr);
            REG_SW:       rd_data = data_t'(sw_sync);
            REG_MTIME_LO: rd_data = mtime_lo;
            REG_MTIME_HI: rd_data = shadow;
            REG_CMP_LO:   rd_data = mtimecmp[31:0];
            REG_CMP_HI:   rd_data = mtimecmp[63:32];
            default:      dec_err = 1'b1;
        endcase
        // Write responses carry no data.
        if (is_wr) rd_data = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= req_valid;
            rsp_err   <= req_valid && dec_err;
            rsp_rdata <= req_valid ? rd_data : '0;
        end
    end

endmodule
